// File: rtl/tlb_unit.sv
// Joint dual-page TLB for CP0: serial TLBWI/TLBWR/TLBR/TLBP engine plus one
// registered translation lookup port. Fixed 4 KB pages, PageMask ignored.
package tlb_pkg;
    typedef struct packed {
        logic [31:0] index;
        logic [31:0] random;
        logic [31:0] entryhi;
        logic [31:0] pagemask;
        logic [31:0] entrylo0;
        logic [31:0] entrylo1;
    } tlb_t;
endpackage

module tlb_unit
    import tlb_pkg::*;
#(
    parameter int INDEX_WIDTH = 5,
    parameter int TLB_SIZE    = 2**INDEX_WIDTH,
    parameter int PABITS      = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_req,
    input  logic [1:0]        op_type,
    input  tlb_t              write_tlb,
    output logic              op_done,
    output tlb_t              read_tlb,
    input  logic [31:0]       lk_vaddr,
    input  logic [7:0]        lk_asid,
    input  logic              lk_en,
    output logic              lk_hit,
    output logic              lk_valid,
    output logic              lk_dirty,
    output logic [2:0]        lk_cattr,
    output logic [PABITS-1:0] lk_paddr,
    output logic [2:0]        state_dbg
);

    localparam int PFN_W = PABITS - 12;

    localparam logic [1:0] OP_TLBWI = 2'd0;
    localparam logic [1:0] OP_TLBWR = 2'd1;
    localparam logic [1:0] OP_TLBR  = 2'd2;
    localparam logic [1:0] OP_TLBP  = 2'd3;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_CMP  = 3'd1,
        S_PENC = 3'd2,
        S_EXEC = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t state;
    logic [1:0] op_q;
    logic [TLB_SIZE-1:0] pmatch_q;

    logic [18:0]      vpn2_q [TLB_SIZE];
    logic [7:0]       asid_q [TLB_SIZE];
    logic [PFN_W-1:0] pfn0_q [TLB_SIZE];
    logic [PFN_W-1:0] pfn1_q [TLB_SIZE];
    logic [2:0]       c0_q   [TLB_SIZE];
    logic [2:0]       c1_q   [TLB_SIZE];
    logic [TLB_SIZE-1:0] g_q, d0_q, d1_q, v0_q, v1_q;

    logic [TLB_SIZE-1:0]    lk_match, p_match;
    logic [INDEX_WIDTH-1:0] lk_idx, rd_idx, wr_idx;
    logic                   wr_en;

    assign state_dbg = state;
    assign rd_idx = write_tlb.index[INDEX_WIDTH-1:0];
    assign wr_idx = (op_q == OP_TLBWR) ? write_tlb.random[INDEX_WIDTH-1:0]
                                       : write_tlb.index[INDEX_WIDTH-1:0];
    assign wr_en  = (state == S_EXEC) && !op_q[1];

    // Lowest set bit wins: scanning downward leaves the smallest index last.
    function automatic logic [INDEX_WIDTH-1:0] first_set(input logic [TLB_SIZE-1:0] vec);
        first_set = '0;
        for (int i = TLB_SIZE - 1; i >= 0; i--) begin
            if (vec[i]) first_set = INDEX_WIDTH'(i);
        end
    endfunction

    always_comb begin
        lk_match = '0;
        p_match  = '0;
        for (int i = 0; i < TLB_SIZE; i++) begin
            lk_match[i] = (vpn2_q[i] == lk_vaddr[31:13]) &&
                          (g_q[i] || (asid_q[i] == lk_asid));
            p_match[i]  = (vpn2_q[i] == write_tlb.entryhi[31:13]) &&
                          (g_q[i] || (asid_q[i] == write_tlb.entryhi[7:0]));
        end
    end

    assign lk_idx = first_set(lk_match);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TLB_SIZE; i++) begin
                vpn2_q[i] <= '0;
                asid_q[i] <= '0;
                pfn0_q[i] <= '0;
                pfn1_q[i] <= '0;
                c0_q[i]   <= '0;
                c1_q[i]   <= '0;
            end
            g_q  <= '0;
            d0_q <= '0;
            d1_q <= '0;
            v0_q <= '0;
            v1_q <= '0;
        end else if (wr_en) begin
            vpn2_q[wr_idx] <= write_tlb.entryhi[31:13];
            asid_q[wr_idx] <= write_tlb.entryhi[7:0];
            g_q[wr_idx]    <= write_tlb.entrylo0[0] & write_tlb.entrylo1[0];
            pfn0_q[wr_idx] <= write_tlb.entrylo0[PABITS-7:6];
            pfn1_q[wr_idx] <= write_tlb.entrylo1[PABITS-7:6];
            c0_q[wr_idx]   <= write_tlb.entrylo0[5:3];
            c1_q[wr_idx]   <= write_tlb.entrylo1[5:3];
            d0_q[wr_idx]   <= write_tlb.entrylo0[2];
            d1_q[wr_idx]   <= write_tlb.entrylo1[2];
            v0_q[wr_idx]   <= write_tlb.entrylo0[1];
            v1_q[wr_idx]   <= write_tlb.entrylo1[1];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            op_q     <= OP_TLBWI;
            pmatch_q <= '0;
            op_done  <= 1'b0;
            read_tlb <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    op_done <= 1'b0;
                    if (op_req) begin
                        op_q  <= op_type;
                        state <= (op_type == OP_TLBP) ? S_CMP : S_EXEC;
                    end
                end
                S_CMP: begin
                    pmatch_q <= p_match;
                    state    <= S_PENC;
                end
                S_PENC: begin
                    read_tlb.index <= (|pmatch_q)
                        ? {{(32-INDEX_WIDTH){1'b0}}, first_set(pmatch_q)}
                        : 32'h8000_0000;
                    op_done <= 1'b1;
                    state   <= S_DONE;
                end
                S_EXEC: begin
                    if (op_q == OP_TLBR) begin
                        read_tlb.entryhi  <= {vpn2_q[rd_idx], 5'b0, asid_q[rd_idx]};
                        read_tlb.pagemask <= '0;
                        read_tlb.entrylo0 <= {{(38-PABITS){1'b0}}, pfn0_q[rd_idx], c0_q[rd_idx],
                                              d0_q[rd_idx], v0_q[rd_idx], g_q[rd_idx]};
                        read_tlb.entrylo1 <= {{(38-PABITS){1'b0}}, pfn1_q[rd_idx], c1_q[rd_idx],
                                              d1_q[rd_idx], v1_q[rd_idx], g_q[rd_idx]};
                    end
                    op_done <= 1'b1;
                    state   <= S_DONE;
                end
                S_DONE: begin
                    op_done <= 1'b0;
                    state   <= S_IDLE;
                end
                default: begin
                    op_done <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    // Lookup reads the array as it stood before this edge's write.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lk_hit   <= 1'b0;
            lk_valid <= 1'b0;
            lk_dirty <= 1'b0;
            lk_cattr <= '0;
            lk_paddr <= '0;
        end else if (lk_en) begin
            lk_hit <= |lk_match;
            if (!(|lk_match)) begin
                lk_valid <= 1'b0;
                lk_dirty <= 1'b0;
                lk_cattr <= '0;
                lk_paddr <= '0;
            end else if (lk_vaddr[12]) begin
                lk_valid <= v1_q[lk_idx];
                lk_dirty <= d1_q[lk_idx];
                lk_cattr <= c1_q[lk_idx];
                lk_paddr <= {pfn1_q[lk_idx], lk_vaddr[11:0]};
            end else begin
                lk_valid <= v0_q[lk_idx];
                lk_dirty <= d0_q[lk_idx];
                lk_cattr <= c0_q[lk_idx];
                lk_paddr <= {pfn0_q[lk_idx], lk_vaddr[11:0]};
            end
        end else begin
            lk_hit <= 1'b0;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{write_tlb.index[31:INDEX_WIDTH], write_tlb.random[31:INDEX_WIDTH],
                           write_tlb.entryhi[12:8], write_tlb.pagemask,
                           write_tlb.entrylo0[31:PABITS-6], write_tlb.entrylo1[31:PABITS-6]};

endmodule

// File: tb/tb_tlb_unit.sv
// Self-checking bench for tlb_unit: directed scenarios plus randomized
// management ops and lookups compared against an entry-table model.
module tb_tlb_unit;
    import tlb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        op_req = 1'b0;
    logic [1:0]  op_type = 2'd0;
    tlb_t        write_tlb = '0;
    logic        op_done;
    tlb_t        read_tlb;
    logic [31:0] lk_vaddr = '0;
    logic [7:0]  lk_asid = '0;
    logic        lk_en = 1'b0;
    logic        lk_hit, lk_valid, lk_dirty;
    logic [2:0]  lk_cattr;
    logic [31:0] lk_paddr;
    logic [2:0]  state_dbg;

    tlb_unit #(.INDEX_WIDTH(5), .PABITS(32)) dut (
        .clk(clk), .rst(rst), .op_req(op_req), .op_type(op_type),
        .write_tlb(write_tlb), .op_done(op_done), .read_tlb(read_tlb),
        .lk_vaddr(lk_vaddr), .lk_asid(lk_asid), .lk_en(lk_en),
        .lk_hit(lk_hit), .lk_valid(lk_valid), .lk_dirty(lk_dirty),
        .lk_cattr(lk_cattr), .lk_paddr(lk_paddr), .state_dbg(state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // reference model: plain table of entries
    int unsigned m_vpn2 [32];
    int unsigned m_asid [32];
    int unsigned m_g    [32];
    int unsigned m_pfn  [32][2];
    int unsigned m_c    [32][2];
    int unsigned m_d    [32][2];
    int unsigned m_v    [32][2];
    tlb_t        m_rd;
    logic [31:0] m_lk_paddr;
    logic        m_lk_valid, m_lk_dirty;

    // scoreboard: {hit, valid, dirty, cattr, paddr}
    logic [37:0] exp_q[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            m_vpn2[i] = 0; m_asid[i] = 0; m_g[i] = 0;
            for (int p = 0; p < 2; p++) begin
                m_pfn[i][p] = 0; m_c[i][p] = 0; m_d[i][p] = 0; m_v[i][p] = 0;
            end
        end
        m_rd = '0;
        m_lk_paddr = '0; m_lk_valid = 1'b0; m_lk_dirty = 1'b0;
    endtask

    task automatic model_write(input int unsigned idx, input tlb_t w);
        int unsigned e;
        int unsigned lo [2];
        e = idx % 32;
        lo[0] = w.entrylo0;
        lo[1] = w.entrylo1;
        m_vpn2[e] = w.entryhi / 8192;
        m_asid[e] = w.entryhi % 256;
        m_g[e] = lo[0] & lo[1] & 1;
        for (int p = 0; p < 2; p++) begin
            m_pfn[e][p] = (lo[p] / 64) % 1048576;
            m_c[e][p]   = (lo[p] / 8) % 8;
            m_d[e][p]   = (lo[p] / 4) % 2;
            m_v[e][p]   = (lo[p] / 2) % 2;
        end
    endtask

    function automatic int model_find(input int unsigned vpn2, input int unsigned asid);
        for (int i = 0; i < 32; i++)
            if (m_vpn2[i] == vpn2 && (m_g[i] != 0 || m_asid[i] == asid)) return i;
        return -1;
    endfunction

    function automatic logic [31:0] model_lo(input int unsigned e, input int p);
        return m_pfn[e][p] * 64 + m_c[e][p] * 8 + m_d[e][p] * 4 + m_v[e][p] * 2 + m_g[e];
    endfunction

    // driver: one management op, checked for latency and read_tlb contents
    task automatic do_op(input logic [1:0] t, input tlb_t w);
        int lat;
        int k;
        int unsigned e;
        @(negedge clk);
        op_type = t;
        write_tlb = w;
        op_req = 1'b1;
        lat = 0;
        while (lat < 10) begin
            @(posedge clk); #1;
            lat++;
            if (op_done) break;
        end
        op_req = 1'b0;
        check("op_latency", lat, (t == 2'd3) ? 3 : 2);
        case (t)
            2'd0: model_write(w.index, w);
            2'd1: model_write(w.random, w);
            2'd2: begin
                e = w.index % 32;
                m_rd.entryhi  = m_vpn2[e] * 8192 + m_asid[e];
                m_rd.pagemask = '0;
                m_rd.entrylo0 = model_lo(e, 0);
                m_rd.entrylo1 = model_lo(e, 1);
            end
            default: begin
                k = model_find(w.entryhi / 8192, w.entryhi % 256);
                m_rd.index = (k < 0) ? 32'h8000_0000 : k;
            end
        endcase
        check("rd_index", read_tlb.index, m_rd.index);
        check("rd_random", read_tlb.random, m_rd.random);
        check("rd_entryhi", read_tlb.entryhi, m_rd.entryhi);
        check("rd_pagemask", read_tlb.pagemask, m_rd.pagemask);
        check("rd_entrylo0", read_tlb.entrylo0, m_rd.entrylo0);
        check("rd_entrylo1", read_tlb.entrylo1, m_rd.entrylo1);
        @(posedge clk); #1;
        check("op_done_pulse", op_done, 1'b0);
    endtask

    // driver: one lookup cycle, expected value queued before the sampling edge
    task automatic lookup(input logic [31:0] va, input logic [7:0] asid);
        int k;
        int p;
        logic [37:0] e;
        logic [37:0] got;
        @(negedge clk);
        lk_en = 1'b1;
        lk_vaddr = va;
        lk_asid = asid;
        k = model_find(va / 8192, asid);
        p = (va / 4096) % 2;
        if (k < 0) e = '0;
        else e = {1'b1, m_v[k][p][0], m_d[k][p][0], m_c[k][p][2:0],
                  m_pfn[k][p] * 4096 + va % 4096};
        exp_q.push_back(e);
        @(posedge clk); #1;
        lk_en = 1'b0;
        e = exp_q.pop_front();
        got = {lk_hit, lk_valid, lk_dirty, lk_cattr, lk_paddr};
        check("lk_hit", lk_hit, e[37]);
        check("lk_valid", lk_valid, e[36]);
        check("lk_dirty", lk_dirty, e[35]);
        check("lk_paddr", lk_paddr, e[31:0]);
        if (e[37]) check("lk_cattr", lk_cattr, e[34:32]);
        m_lk_valid = e[36]; m_lk_dirty = e[35]; m_lk_paddr = e[31:0];
    endtask

    task automatic lookup_idle();
        @(negedge clk);
        lk_en = 1'b0;
        @(posedge clk); #1;
        check("idle_hit", lk_hit, 1'b0);
        check("idle_valid_hold", lk_valid, m_lk_valid);
        check("idle_paddr_hold", lk_paddr, m_lk_paddr);
    endtask

    function automatic logic [31:0] pick_vpn2();
        case ($urandom_range(0, 3))
            0: return 32'h201;
            1: return 32'h800;
            2: return 32'h7FFFF;
            default: return 32'h12345;
        endcase
    endfunction

    tlb_t w;
    int pulses;

    initial begin
        model_clear();
        // reset block
        repeat (3) @(posedge clk);
        #1;
        check("rst_op_done", op_done, 1'b0);
        check("rst_rd_index", read_tlb.index, 32'h0);
        check("rst_rd_entryhi", read_tlb.entryhi, 32'h0);
        check("rst_lk_hit", lk_hit, 1'b0);
        check("rst_lk_paddr", lk_paddr, 32'h0);
        rst = 1'b1;

        // probe of empty TLB
        w = '0; w.entryhi = 32'h0040_2001;
        do_op(2'd3, w);
        check("probe_empty", read_tlb.index, 32'h8000_0000);

        // TLBWI index 5, then probe and read back
        w = '0; w.index = 32'd5; w.entryhi = 32'h0040_2001;
        w.entrylo0 = 32'h0000_1046; w.entrylo1 = 32'h0000_2047;
        do_op(2'd0, w);
        do_op(2'd3, w);
        check("probe_idx5", read_tlb.index, 32'd5);
        do_op(2'd2, w);
        check("tlbr_hi", read_tlb.entryhi, 32'h0040_2001);
        check("tlbr_lo0", read_tlb.entrylo0, 32'h0000_1046);
        check("tlbr_pm", read_tlb.pagemask, 32'h0);

        // lookups on both pages and with a foreign ASID
        lookup(32'h0040_2ABC, 8'h01);
        check("plan_pa0", lk_paddr, 32'h0004_1ABC);
        lookup_idle();
        lookup(32'h0040_3ABC, 8'h01);
        check("plan_pa1", lk_paddr, 32'h0008_1ABC);
        lookup(32'h0040_2ABC, 8'h02);
        check("plan_asid_miss", lk_hit, 1'b0);

        // global entry via TLBWR, then duplicate at a lower index
        w = '0; w.random = 32'd9; w.entryhi = 32'h0100_0005;
        w.entrylo0 = 32'h0000_C013; w.entrylo1 = 32'h0000_C047;
        do_op(2'd1, w);
        lookup(32'h0100_0123, 8'h77);
        check("plan_global_hit", lk_hit, 1'b1);
        w.entryhi = 32'h0100_00AA;
        do_op(2'd3, w);
        check("plan_probe9", read_tlb.index, 32'd9);
        w = '0; w.index = 32'd3; w.entryhi = 32'h0100_0005;
        w.entrylo0 = 32'h0000_5017; w.entrylo1 = 32'h0000_5047;
        do_op(2'd0, w);
        w.entryhi = 32'h0100_00AA;
        do_op(2'd3, w);
        check("plan_probe3", read_tlb.index, 32'd3);
        lookup(32'h0100_0123, 8'h77);
        check("plan_dup_pa", lk_paddr, 32'h0014_0123);

        // lookup in the same cycle as the TLBWI write of index 5
        w = '0; w.index = 32'd5; w.entryhi = 32'h0040_2001;
        w.entrylo0 = 32'h0000_48C6; w.entrylo1 = 32'h0000_2047;
        fork
            do_op(2'd0, w);
            begin
                @(negedge clk);
                @(posedge clk);
                lookup(32'h0040_2000, 8'h01);
                check("same_cyc_old", lk_paddr, 32'h0004_1000);
            end
        join
        lookup(32'h0040_2000, 8'h01);
        check("next_cyc_new", lk_paddr, 32'h0012_3000);

        // randomized management ops and lookups
        for (int it = 0; it < 80; it++) begin
            w = '0;
            w.index = $urandom;
            w.random = $urandom;
            w.entryhi = pick_vpn2() * 8192 + $urandom_range(0, 31) * 256 + $urandom_range(0, 3);
            w.pagemask = $urandom;
            w.entrylo0 = $urandom;
            w.entrylo1 = $urandom;
            case ($urandom_range(0, 4))
                0: do_op(2'd0, w);
                1: do_op(2'd1, w);
                2: do_op(2'd2, w);
                3: do_op(2'd3, w);
                default: lookup(pick_vpn2() * 8192 + $urandom_range(0, 8191),
                                8'($urandom_range(0, 3)));
            endcase
        end

        // reset during TLBP compare
        w = '0; w.entryhi = 32'h0040_2001;
        @(negedge clk);
        op_type = 2'd3;
        write_tlb = w;
        op_req = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        op_req = 1'b0;
        pulses = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (op_done) pulses++;
        end
        rst = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (op_done) pulses++;
        end
        check("rst_mid_no_done", pulses, 0);
        model_clear();
        check("rst_mid_rd_index", read_tlb.index, 32'h0);
        check("rst_mid_rd_hi", read_tlb.entryhi, 32'h0);
        check("rst_mid_rd_lo0", read_tlb.entrylo0, 32'h0);
        check("rst_mid_rd_lo1", read_tlb.entrylo1, 32'h0);
        lookup(32'h0040_2ABC, 8'h01);
        check("rst_mid_lk_miss", lk_hit, 1'b0);
        do_op(2'd3, w);
        check("rst_mid_probe", read_tlb.index, 32'h8000_0000);

        // final report
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
